// File: rtl/lm_port_arbiter.sv
// Two-requester local-memory port arbiter: burst ownership with MAX_BURST forced release and bus lock.
// Define LM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default build is fixed priority to requester 0.
module lm_port_arbiter #(
  parameter int D_WIDTH           = 32,
  parameter int LM_MEM_ADDR_WIDTH = 8,
  parameter int LM_MEM_WIDTH      = 32,
  parameter int MAX_BURST         = 16,
  localparam int NE               = LM_MEM_WIDTH / 8,
  localparam int CW               = $clog2(MAX_BURST + 1)
) (
  input  logic                           iClk,
  input  logic                           iReset_n,
  input  logic [1:0]                     iReq_Valid,
  input  logic [1:0]                     iReq_Write,
  input  logic [1:0]                     iReq_Last,
  input  logic [2*LM_MEM_ADDR_WIDTH-1:0] iReq_Address,
  input  logic [2*D_WIDTH-1:0]           iReq_WriteData,
  input  logic [2*NE-1:0]                iReq_ByteEnable,
  output logic [1:0]                     oReq_Accept,
  output logic [1:0]                     oRsp_Valid,
  output logic [D_WIDTH-1:0]             oRsp_Data,
  output logic [NE-1:0]                  oLM_WriteEnable,
  output logic                           oLM_ReadEnable,
  output logic [LM_MEM_ADDR_WIDTH-1:0]   oLM_WriteAddress,
  output logic [LM_MEM_ADDR_WIDTH-1:0]   oLM_ReadAddress,
  output logic [D_WIDTH-1:0]             oLM_WriteData,
  input  logic [D_WIDTH-1:0]             iLM_ReadData,
  output logic [1:0]                     oDbg_State
);

  // Handshake: a beat transfers on a rising edge where iReq_Valid[x] and oReq_Accept[x] are both high.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rsp_q, rsp_d;

  logic                         sel;
  logic                         owned;
  logic                         v_sel;
  logic                         w_sel;
  logic                         l_sel;
  logic                         fire;
  logic [CW-1:0]                cnt_inc;
  logic [LM_MEM_ADDR_WIDTH-1:0] addr_sel;
  logic [D_WIDTH-1:0]           data_sel;
  logic [NE-1:0]                be_sel;
  state_e                       tie_winner;

`ifdef LM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // Contested grant goes to whoever did not hold the previous one.
  always_comb begin
    tie_winner = last_owner_q ? ST_OWN0 : ST_OWN1;
  end
`else
  always_comb begin
    tie_winner = ST_OWN0;
  end
`endif

  always_comb begin
    owned    = (state_q != ST_IDLE);
    sel      = (state_q == ST_OWN1);
    v_sel    = sel ? iReq_Valid[1] : iReq_Valid[0];
    w_sel    = sel ? iReq_Write[1] : iReq_Write[0];
    l_sel    = sel ? iReq_Last[1]  : iReq_Last[0];
    addr_sel = sel ? iReq_Address[2*LM_MEM_ADDR_WIDTH-1:LM_MEM_ADDR_WIDTH]
                   : iReq_Address[LM_MEM_ADDR_WIDTH-1:0];
    data_sel = sel ? iReq_WriteData[2*D_WIDTH-1:D_WIDTH] : iReq_WriteData[D_WIDTH-1:0];
    be_sel   = sel ? iReq_ByteEnable[2*NE-1:NE] : iReq_ByteEnable[NE-1:0];
    fire     = owned && v_sel;
    cnt_inc  = cnt_q + 1'b1;
  end

  always_comb begin
    oReq_Accept      = 2'b00;
    oLM_WriteEnable  = '0;
    oLM_ReadEnable   = 1'b0;
    oLM_WriteAddress = '0;
    oLM_ReadAddress  = '0;
    oLM_WriteData    = '0;
    if (state_q == ST_OWN0) oReq_Accept[0] = iReq_Valid[0];
    if (state_q == ST_OWN1) oReq_Accept[1] = iReq_Valid[1];
    if (fire && w_sel) begin
      oLM_WriteEnable  = be_sel;
      oLM_WriteAddress = addr_sel;
      oLM_WriteData    = data_sel;
    end
    if (fire && !w_sel) begin
      oLM_ReadEnable  = 1'b1;
      oLM_ReadAddress = addr_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = 2'b00;
`ifdef LM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        case (iReq_Valid)
          2'b01:   state_d = ST_OWN0;
          2'b10:   state_d = ST_OWN1;
          2'b11:   state_d = tie_winner;
          default: state_d = ST_IDLE;
        endcase
`ifdef LM_ARB_ROUND_ROBIN_EN
        if (state_d == ST_OWN0) last_owner_d = 1'b0;
        if (state_d == ST_OWN1) last_owner_d = 1'b1;
`endif
      end
      ST_OWN0, ST_OWN1: begin
        // Missing valid without Last keeps the grant: the owner's burst is locked in.
        if (fire) begin
          if (!w_sel) rsp_d = sel ? 2'b10 : 2'b01;
          if (l_sel || (cnt_inc == CW'(MAX_BURST))) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rsp_q   <= 2'b00;
`ifdef LM_ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
`ifdef LM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Response is tagged with its requester at issue time, so it survives any grant change.
  always_comb begin
    oRsp_Valid = rsp_q;
    oRsp_Data  = (|rsp_q) ? iLM_ReadData : '0;
    oDbg_State = state_q;
  end

endmodule

// File: tb/tb_lm_port_arbiter.sv
// Directed bench for lm_port_arbiter: reset, write/read, arbitration, bus lock, forced release, async reset.
module tb_lm_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NE = 4;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [1:0]      req_last;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*NE-1:0] req_be;
  logic [1:0]      req_accept;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [NE-1:0]   lm_we;
  logic            lm_re;
  logic [AW-1:0]   lm_waddr;
  logic [AW-1:0]   lm_raddr;
  logic [DW-1:0]   lm_wdata;
  logic [DW-1:0]   lm_rdata;
  logic [1:0]      dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  lm_port_arbiter #(
    .D_WIDTH(DW), .LM_MEM_ADDR_WIDTH(AW), .LM_MEM_WIDTH(32), .MAX_BURST(16)
  ) dut (
    .iClk(clk), .iReset_n(rst_n),
    .iReq_Valid(req_valid), .iReq_Write(req_write), .iReq_Last(req_last),
    .iReq_Address(req_addr), .iReq_WriteData(req_wdata), .iReq_ByteEnable(req_be),
    .oReq_Accept(req_accept), .oRsp_Valid(rsp_valid), .oRsp_Data(rsp_data),
    .oLM_WriteEnable(lm_we), .oLM_ReadEnable(lm_re),
    .oLM_WriteAddress(lm_waddr), .oLM_ReadAddress(lm_raddr),
    .oLM_WriteData(lm_wdata), .iLM_ReadData(lm_rdata), .oDbg_State(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [127:0] all_out;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_last  = 2'b00;
    req_addr  = 16'h1234;
    req_wdata = '1;
    req_be    = '1;
    lm_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    all_out = {req_accept, rsp_valid, rsp_data, lm_we, lm_re, lm_waddr, lm_raddr, lm_wdata, dbg_state};
    vec_cnt++;
    if (all_out !== 128'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    req_valid = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    lm_rdata  = '0;
    rst_n     = 1'b1;
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (dbg_state !== 2'd0 || req_accept !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_idle: state %0d accept %b expected 0 00", dbg_state, req_accept);
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    req_valid = 2'b01;
    req_write = 2'b01;
    req_last  = 2'b01;
    req_addr  = {8'h00, 8'h10};
    req_wdata = {32'h0, 32'hA5A5_A5A5};
    req_be    = {4'h0, 4'hF};
    @(negedge clk);
    vec_cnt++;
    if (req_accept !== 2'b00 || lm_we !== 4'h0) begin
      err_cnt++;
      $display("FAIL wr_idle_no_accept: accept %b we %h expected 00 0", req_accept, lm_we);
    end
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if ({req_accept, lm_we, lm_waddr, lm_wdata, lm_re} !== {2'b01, 4'hF, 8'h10, 32'hA5A5_A5A5, 1'b0}) begin
      err_cnt++;
      $display("FAIL wr_beat: acc %b we %h addr %h data %h re %b expected 01 f 10 a5a5a5a5 0",
               req_accept, lm_we, lm_waddr, lm_wdata, lm_re);
    end
    next_cycle();
    req_write = 2'b00;
    @(negedge clk);
    vec_cnt++;
    if (dbg_state !== 2'd0 || req_accept !== 2'b00 || rsp_valid !== 2'b00) begin
      err_cnt++;
      $display("FAIL rd_idle: state %0d acc %b rsp %b expected 0 00 00", dbg_state, req_accept, rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if ({req_accept, lm_re, lm_raddr, lm_we} !== {2'b01, 1'b1, 8'h10, 4'h0}) begin
      err_cnt++;
      $display("FAIL rd_beat: acc %b re %b addr %h we %h expected 01 1 10 0", req_accept, lm_re, lm_raddr, lm_we);
    end
    next_cycle();
    req_valid = 2'b00;
    req_last  = 2'b00;
    lm_rdata  = 32'hA5A5_A5A5;
    @(negedge clk);
    vec_cnt++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'hA5A5_A5A5) begin
      err_cnt++;
      $display("FAIL rd_rsp: valid %b data %h expected 01 a5a5a5a5", rsp_valid, rsp_data);
    end
    next_cycle();
    lm_rdata = '0;
    @(negedge clk);
    vec_cnt++;
    if (rsp_valid !== 2'b00) begin
      err_cnt++;
      $display("FAIL rd_rsp_single: valid %b expected 00", rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_arbitration();
    int bcnt[2];
    int grant_q[$];
    int exp_grant[4];
    int cyc;
    logic [1:0] a;
`ifdef LM_ARB_ROUND_ROBIN_EN
    exp_grant = '{0, 1, 0, 1};
`else
    exp_grant = '{0, 0, 1, 1};
`endif
    bcnt[0] = 0;
    bcnt[1] = 0;
    cyc = 0;
    req_write = 2'b11;
    req_be    = 8'hFF;
    while ((bcnt[0] < 6 || bcnt[1] < 6) && cyc < 40) begin
      for (int r = 0; r < 2; r++) begin
        req_valid[r] = (bcnt[r] < 6);
        req_last[r]  = ((bcnt[r] % 3) == 2);
      end
      req_addr  = {8'(8'h40 + bcnt[1]), 8'(8'h20 + bcnt[0])};
      req_wdata = {32'(bcnt[1]), 32'(bcnt[0])};
      @(negedge clk);
      a = req_accept;
      vec_cnt++;
      if (a == 2'b11 || (a == 2'b01 && lm_waddr !== 8'(8'h20 + bcnt[0]))
          || (a == 2'b10 && lm_waddr !== 8'(8'h40 + bcnt[1]))) begin
        err_cnt++;
        $display("FAIL arb_beat: accept %b waddr %h cycle %0d", a, lm_waddr, cyc);
      end
      for (int r = 0; r < 2; r++) begin
        if (a[r]) begin
          if ((bcnt[r] % 3) == 0) grant_q.push_back(r);
          bcnt[r]++;
        end
      end
      next_cycle();
      cyc++;
    end
    req_valid = 2'b00;
    req_last  = 2'b00;
    vec_cnt++;
    if (grant_q.size() != 4) begin
      err_cnt++;
      $display("FAIL arb_grant_count: got %0d bursts expected 4 (cycles %0d)", grant_q.size(), cyc);
    end
    for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
      vec_cnt++;
      if (grant_q[i] != exp_grant[i]) begin
        err_cnt++;
        $display("FAIL arb_order[%0d]: got %0d expected %0d", i, grant_q[i], exp_grant[i]);
      end
    end
    next_cycle();
  endtask

  task automatic test_bus_lock();
    req_valid = 2'b01;
    req_write = 2'b11;
    req_last  = 2'b00;
    req_addr  = {8'h60, 8'h50};
    @(negedge clk);
    vec_cnt++;
    if (req_accept !== 2'b00) begin
      err_cnt++;
      $display("FAIL lock_idle: accept %b expected 00", req_accept);
    end
    next_cycle();
    repeat (2) begin
      @(negedge clk);
      vec_cnt++;
      if (req_accept !== 2'b01) begin
        err_cnt++;
        $display("FAIL lock_first_beats: accept %b expected 01", req_accept);
      end
      next_cycle();
    end
    req_valid = 2'b10;
    repeat (5) begin
      @(negedge clk);
      vec_cnt++;
      if (req_accept !== 2'b00 || dbg_state !== 2'd1) begin
        err_cnt++;
        $display("FAIL lock_hold: accept %b state %0d expected 00 1", req_accept, dbg_state);
      end
      next_cycle();
    end
    req_valid = 2'b11;
    req_last  = 2'b01;
    @(negedge clk);
    vec_cnt++;
    if (req_accept !== 2'b01) begin
      err_cnt++;
      $display("FAIL lock_last: accept %b expected 01", req_accept);
    end
    next_cycle();
    req_valid = 2'b10;
    req_last  = 2'b10;
    @(negedge clk);
    vec_cnt++;
    if (req_accept !== 2'b00 || dbg_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL lock_release_idle: accept %b state %0d expected 00 0", req_accept, dbg_state);
    end
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (req_accept !== 2'b10) begin
      err_cnt++;
      $display("FAIL lock_other_grant: accept %b expected 10", req_accept);
    end
    next_cycle();
    req_valid = 2'b00;
    req_last  = 2'b00;
    next_cycle();
  endtask

  task automatic test_forced_release();
    int beats;
    int c;
    logic exp_acc;
    beats     = 0;
    c         = 0;
    req_valid = 2'b10;
    req_write = 2'b10;
    req_last  = 2'b00;
    while (beats < 40 && c < 60) begin
      req_addr = {8'(beats), 8'h00};
      @(negedge clk);
      exp_acc = !(c == 0 || c == 17 || c == 34);
      vec_cnt++;
      if (req_accept !== {exp_acc, 1'b0}) begin
        err_cnt++;
        $display("FAIL burst_accept: cycle %0d accept %b expected %b", c, req_accept, {exp_acc, 1'b0});
      end
      if (c == 17 || c == 34) begin
        vec_cnt++;
        if (dbg_state !== 2'd0) begin
          err_cnt++;
          $display("FAIL burst_release_idle: cycle %0d state %0d expected 0", c, dbg_state);
        end
      end
      if (req_accept[1]) beats++;
      next_cycle();
      c++;
    end
    vec_cnt++;
    if (beats != 40 || c != 43) begin
      err_cnt++;
      $display("FAIL burst_timing: beats %0d cycles %0d expected 40 43", beats, c);
    end
    req_last = 2'b10;
    @(negedge clk);
    vec_cnt++;
    if (req_accept !== 2'b10) begin
      err_cnt++;
      $display("FAIL burst_close: accept %b expected 10", req_accept);
    end
    next_cycle();
    req_valid = 2'b00;
    req_last  = 2'b00;
    @(negedge clk);
    vec_cnt++;
    if (dbg_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL burst_close_idle: state %0d expected 0", dbg_state);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    logic [127:0] all_out;
    req_valid = 2'b01;
    req_write = 2'b00;
    req_last  = 2'b00;
    req_addr  = {8'h00, 8'h33};
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (req_accept !== 2'b01 || lm_re !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_read_beat: accept %b re %b expected 01 1", req_accept, lm_re);
    end
    @(posedge clk);
    #2;
    lm_rdata = 32'hDEAD_BEEF;
    rst_n    = 1'b0;
    #1;
    all_out = {req_accept, rsp_valid, rsp_data, lm_we, lm_re, lm_waddr, lm_raddr, lm_wdata, dbg_state};
    vec_cnt++;
    if (all_out !== 128'd0) begin
      err_cnt++;
      $display("FAIL rst_async_outputs: got %h expected 0", all_out);
    end
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (rsp_valid !== 2'b00 || dbg_state !== 2'd0 || rsp_data !== 32'd0) begin
      err_cnt++;
      $display("FAIL rst_after_release: rsp %b state %0d data %h expected 00 0 0", rsp_valid, dbg_state, rsp_data);
    end
    lm_rdata = '0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_arbitration();
    test_bus_lock();
    test_forced_release();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
